// File: rtl/fc_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : fc_mac_accumulator
//  Description : Streams activation/weight pairs for one FC neuron, multiplies
//                them (unsigned), and accumulates into a saturating sum. The
//                sum is presented with the latched layer select to the
//                downstream rescale stage through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_mac_accumulator #(
  parameter int unsigned BITWIDTH_ACT = 8,
  parameter int unsigned BITWIDTH_W   = 8,
  parameter int unsigned BITWIDTH_OUT = 24,
  parameter int unsigned LEN0         = 784,
  parameter int unsigned LEN1         = 128,
  parameter int unsigned LEN2         = 64,
  parameter int unsigned CNT_W        = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [1:0]              layer_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITWIDTH_ACT-1:0] act,
  input  logic [BITWIDTH_W-1:0]   wt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITWIDTH_OUT-1:0] out_data,
  output logic [1:0]              out_select,
  output logic                    out_sat,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned C_PW = BITWIDTH_ACT + BITWIDTH_W;

  // Terminal beat index per layer (beat count minus one)
  localparam logic [CNT_W-1:0] c_last0 = CNT_W'(LEN0 - 1);
  localparam logic [CNT_W-1:0] c_last1 = CNT_W'(LEN1 - 1);
  localparam logic [CNT_W-1:0] c_last2 = CNT_W'(LEN2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_sel;
  logic [CNT_W-1:0]        r_last;
  logic [CNT_W-1:0]        r_count;
  logic [C_PW-1:0]         r_prod;
  logic                    r_prod_v;
  logic [BITWIDTH_OUT-1:0] r_acc;
  logic                    r_sat;
  logic [BITWIDTH_OUT-1:0] r_out_data;
  logic [1:0]              r_out_select;
  logic                    r_err;

  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_start_ok;
  logic                    w_start_bad;
  logic [CNT_W-1:0]        w_last_sel;
  logic [C_PW-1:0]         w_prod;
  logic [BITWIDTH_OUT:0]   w_sum;
  logic [BITWIDTH_OUT-1:0] w_acc_nxt;

  // Starts are only honoured in IDLE; the all-ones select is an illegal layer
  assign w_start_ok  = (r_state == S_IDLE) && start && (layer_sel != 2'b11);
  assign w_start_bad = (r_state == S_IDLE) && start && (layer_sel == 2'b11);
  assign w_beat      = in_valid && (r_state == S_ACCUM);
  assign w_last_beat = w_beat && (r_count == r_last);

  assign w_prod = {{BITWIDTH_W{1'b0}}, act} * {{BITWIDTH_ACT{1'b0}}, wt};

  // One guard bit above the accumulator detects overflow of the addition
  assign w_sum = {1'b0, r_acc} + {{(BITWIDTH_OUT + 1 - C_PW){1'b0}}, r_prod};

  // Accumulator value after this cycle's pending product (clamped on overflow)
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_prod_v) begin
      w_acc_nxt = w_sum[BITWIDTH_OUT] ? {BITWIDTH_OUT{1'b1}} : w_sum[BITWIDTH_OUT-1:0];
    end
  end

  // Beat count for the layer chosen at start
  always_comb begin
    case (layer_sel)
      2'd0:    w_last_sel = c_last0;
      2'd1:    w_last_sel = c_last1;
      default: w_last_sel = c_last2;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)  w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last_beat) w_state_nxt = S_DRAIN;
      S_DRAIN:                  w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: product pipeline, saturating accumulate and output capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel        <= 2'd0;
      r_last       <= '0;
      r_count      <= '0;
      r_prod       <= '0;
      r_prod_v     <= 1'b0;
      r_acc        <= '0;
      r_sat        <= 1'b0;
      r_out_data   <= '0;
      r_out_select <= 2'd0;
      r_err        <= 1'b0;
    end else begin
      r_err    <= w_start_bad;
      r_prod_v <= w_beat;
      if (w_beat) begin
        r_prod  <= w_prod;
        r_count <= r_count + c_cnt_one;
      end
      if (w_start_ok) begin
        r_sel   <= layer_sel;
        r_last  <= w_last_sel;
        r_count <= '0;
        r_acc   <= '0;
        r_sat   <= 1'b0;
      end else if (r_prod_v) begin
        r_acc <= w_acc_nxt;
        if (w_sum[BITWIDTH_OUT]) r_sat <= 1'b1;
      end
      // The final product lands during DRAIN, so capture the post-add value
      if (r_state == S_DRAIN) begin
        r_out_data   <= w_acc_nxt;
        r_out_select <= r_sel;
      end
    end
  end

  assign in_ready   = (r_state == S_ACCUM);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_data   = r_out_data;
  assign out_select = r_out_select;
  assign out_sat    = r_sat;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fc_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_mac_accumulator
//  Description : Directed scoreboard bench for fc_mac_accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_mac_accumulator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  layer_sel;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  act;
  logic [7:0]  wt;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [1:0]  out_select;
  logic        out_sat;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [26:0] sb_q[$];   // {sat, select, data}

  fc_mac_accumulator dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .layer_sel  (layer_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .act        (act),
    .wt         (wt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_select (out_select),
    .out_sat    (out_sat),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sum for one neuron of n identical beats
  function automatic logic [26:0] model(input logic [1:0] sel, input int n, input int a, input int w);
    longint acc = 0;
    logic   sat = 1'b0;
    logic [23:0] d;
    for (int i = 0; i < n; i++) begin
      acc += a * w;
      if (acc > 64'hFFFFFF) begin
        acc = 64'hFFFFFF;
        sat = 1'b1;
      end
    end
    d = acc[23:0];
    return {sat, sel, d};
  endfunction

  task automatic start_neuron(input logic [1:0] sel);
    layer_sel = sel;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic feed(input int n, input int a, input int w, input bit gap);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      act      = a[7:0];
      wt       = w[7:0];
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check("feed_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int t = 0;
    logic [26:0] e;
    while (!out_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_rise", out_valid, 1'b1);
    check("sb_nonempty", sb_q.size() != 0, 1'b1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 27'h0;
    check("out_data", out_data, e[23:0]);
    check("out_select", out_select, e[25:24]);
    check("out_sat", out_sat, e[26]);
    for (int i = 0; i < hold; i++) begin
      // start (even illegal) must be ignored while DONE
      start     = 1'b1;
      layer_sel = 2'b11;
      @(negedge clk);
      check("hold_data", out_data, e[23:0]);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_err", err, 1'b0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", out_valid, 1'b0);
    check("busy_after_hs", busy, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; layer_sel = 2'd0; in_valid = 1'b0;
    act = 8'd0; wt = 8'd0; out_ready = 1'b0;

    // 1: reset state
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 24'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 2: layer 2, back-to-back beats, latency check
    sb_q.push_back(model(2'd2, 64, 2, 3));
    start_neuron(2'd2);
    feed(64, 2, 3, 1'b0);
    check("lat_drain_valid", out_valid, 1'b0);
    check("lat_drain_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("lat_done_valid", out_valid, 1'b1);
    collect(0);

    // 3: layer 1 with input gaps and a stalled consumer
    sb_q.push_back(model(2'd1, 128, 1, 1));
    start_neuron(2'd1);
    feed(128, 1, 1, 1'b1);
    collect(10);

    // 4: layer 0 saturating, then a clean neuron clears the sticky flag
    sb_q.push_back(model(2'd0, 784, 255, 255));
    start_neuron(2'd0);
    feed(784, 255, 255, 1'b0);
    collect(0);
    sb_q.push_back(model(2'd2, 64, 0, 5));
    start_neuron(2'd2);
    check("sat_cleared_on_start", out_sat, 1'b0);
    feed(64, 0, 5, 1'b0);
    collect(0);

    // 5: illegal layer select
    layer_sel = 2'b11;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, 1'b1);
    check("err_busy", busy, 1'b0);
    check("err_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("err_one_cycle", err, 1'b0);
    check("err_busy2", busy, 1'b0);

    // 6: reset mid-neuron aborts it; next neuron is unaffected
    start_neuron(2'd0);
    feed(30, 1, 1, 1'b0);
    rstn = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_data", out_data, 24'h0);
    check("abort_out_select", out_select, 2'd0);
    check("abort_out_sat", out_sat, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_err", err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    sb_q.push_back(model(2'd1, 128, 1, 1));
    start_neuron(2'd1);
    feed(128, 1, 1, 1'b0);
    collect(0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
